// File: rtl/qpsk_pkg.sv
// Shared QPSK types, reference tables and symbol encodings for the
// waveform generators and the symbol demodulator.
package qpsk_pkg;

  localparam int SPS      = 16;
  localparam int MID      = 141;
  localparam int SAMPLE_W = 9;
  localparam int XC_W     = 10;
  localparam int COEF_W   = 8;
  localparam int PROD_W   = 18;
  localparam int ACC_W    = 22;

  typedef logic [SAMPLE_W-1:0]      sample_t;
  typedef logic signed [XC_W-1:0]   centered_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic [3:0]               idx_t;

  // {cos_bit, sin_bit}: 1 selects the positive carrier component
  typedef enum logic [1:0] {
    SYM_00 = 2'b00,
    SYM_01 = 2'b01,
    SYM_10 = 2'b10,
    SYM_11 = 2'b11
  } sym_e;

  localparam coef_t COS_LUT [SPS] = '{
    8'sd127,  8'sd117,  8'sd90,   8'sd49,
    8'sd0,   -8'sd49,  -8'sd90,  -8'sd117,
   -8'sd127, -8'sd117, -8'sd90,  -8'sd49,
    8'sd0,    8'sd49,   8'sd90,   8'sd117
  };

  localparam coef_t SIN_LUT [SPS] = '{
    8'sd0,    8'sd49,   8'sd90,   8'sd117,
    8'sd127,  8'sd117,  8'sd90,   8'sd49,
    8'sd0,   -8'sd49,  -8'sd90,  -8'sd117,
   -8'sd127, -8'sd117, -8'sd90,  -8'sd49
  };

  function automatic acc_t acc_abs(input acc_t a);
    return a[ACC_W-1] ? -a : a;
  endfunction

endpackage

// File: rtl/qpsk_correlator.sv
// One MAC lane of the QPSK demodulator: table lookup, multiply and
// accumulate over a symbol period; sum_o is the running total incl. this sample.
module qpsk_correlator
  import qpsk_pkg::*;
#(
  parameter bit LANE_SIN = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en_i,
  input  logic      first_i,
  input  centered_t xc_i,
  input  idx_t      k_i,
  output acc_t      sum_o
);

  coef_t coef;
  prod_t prod;
  acc_t  acc_q;
  acc_t  base;

  assign coef  = LANE_SIN ? SIN_LUT[k_i] : COS_LUT[k_i];
  assign prod  = prod_t'(xc_i) * prod_t'(coef);
  assign base  = first_i ? acc_t'(0) : acc_q;
  assign sum_o = base + acc_t'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_o;
    end
  end

endmodule

// File: rtl/qpsk_symbol_demod.sv
// QPSK symbol demodulator: hunts for sym_sync, correlates 16 samples per symbol.
// Optional low-confidence flag sym_err under QPSK_DEMOD_SYM_ERR_EN.
module qpsk_symbol_demod
  import qpsk_pkg::*;
#(
  parameter int DATA_W = qpsk_pkg::SAMPLE_W,
  parameter int MID    = qpsk_pkg::MID
`ifdef QPSK_DEMOD_SYM_ERR_EN
  ,
  parameter int ERR_THRESH = 20000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              sym_sync,
  output logic [1:0]        sym_out,
  output logic              sym_valid,
  output logic              locked
`ifdef QPSK_DEMOD_SYM_ERR_EN
  ,
  output logic              sym_err
`endif
);

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_e;

  state_e state_q, state_d;
  idx_t   k_q, k_d, cur_k;
  logic   take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // A sync-qualified sample always becomes k=0, which also drops a partial symbol
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    take    = 1'b0;
    cur_k   = sym_sync ? idx_t'(0) : k_q;
    unique case (state_q)
      HUNT: begin
        if (sample_valid && sym_sync) begin
          take    = 1'b1;
          state_d = TRACK;
          k_d     = idx_t'(1);
        end
      end
      TRACK: begin
        if (sample_valid) begin
          take = 1'b1;
          k_d  = cur_k + idx_t'(1);
        end
      end
      default: state_d = HUNT;
    endcase
  end

  logic      s1_valid_q;
  logic      s1_last_q;
  centered_t s1_xc_q;
  idx_t      s1_k_q;
  centered_t xc_d;

  assign xc_d = centered_t'({1'b0, sample_in}) - centered_t'(MID);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_xc_q    <= '0;
      s1_k_q     <= '0;
    end else begin
      s1_valid_q <= take;
      if (take) begin
        s1_xc_q   <= xc_d;
        s1_k_q    <= cur_k;
        s1_last_q <= (cur_k == idx_t'(SPS - 1));
      end
    end
  end

  acc_t sum_i, sum_q;
  logic first;

  assign first = (s1_k_q == idx_t'(0));

  qpsk_correlator #(.LANE_SIN(1'b0)) u_corr_i (
    .clk     (clk),
    .rst     (rst),
    .en_i    (s1_valid_q),
    .first_i (first),
    .xc_i    (s1_xc_q),
    .k_i     (s1_k_q),
    .sum_o   (sum_i)
  );

  qpsk_correlator #(.LANE_SIN(1'b1)) u_corr_q (
    .clk     (clk),
    .rst     (rst),
    .en_i    (s1_valid_q),
    .first_i (first),
    .xc_i    (s1_xc_q),
    .k_i     (s1_k_q),
    .sum_o   (sum_q)
  );

  logic       dec;
  logic [1:0] sym_q;
  logic       sym_valid_q;

  assign dec = s1_valid_q && s1_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
    end else begin
      sym_valid_q <= dec;
      if (dec) begin
        sym_q <= {sum_i > acc_t'(0), sum_q > acc_t'(0)};
      end
    end
  end

  assign sym_out   = sym_q;
  assign sym_valid = sym_valid_q;
  assign locked    = (state_q == TRACK);

`ifdef QPSK_DEMOD_SYM_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (dec) begin
      err_q <= (acc_abs(sum_i) < acc_t'(ERR_THRESH)) ||
               (acc_abs(sum_q) < acc_t'(ERR_THRESH));
    end
  end

  assign sym_err = err_q;
`endif

endmodule

// File: tb/tb_qpsk_symbol_demod.sv
// Scoreboard bench for qpsk_symbol_demod; checks sym_err when
// QPSK_DEMOD_SYM_ERR_EN is defined.
module tb_qpsk_symbol_demod;

  logic       clk;
  logic       rst;
  logic [8:0] sample_in;
  logic       sample_valid;
  logic       sym_sync;
  logic [1:0] sym_out;
  logic       sym_valid;
  logic       locked;
`ifdef QPSK_DEMOD_SYM_ERR_EN
  logic       sym_err;
`endif

  qpsk_symbol_demod dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sym_sync     (sym_sync),
    .sym_out      (sym_out),
    .sym_valid    (sym_valid),
    .locked       (locked)
`ifdef QPSK_DEMOD_SYM_ERR_EN
    ,
    .sym_err      (sym_err)
`endif
  );

  typedef struct {
    logic [1:0] sym;
    logic       err;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // 141 + 100*(+-cos +- sin), indexed by symbol value
  int wave [4][16] = '{
    '{41, 10, 0, 10, 41, 87, 141, 195, 241, 272, 282, 272, 241, 195, 141, 87},
    '{41, 87, 141, 195, 241, 272, 282, 272, 241, 195, 141, 87, 41, 10, 0, 10},
    '{241, 195, 141, 87, 41, 10, 0, 10, 41, 87, 141, 195, 241, 272, 282, 272},
    '{241, 272, 282, 272, 241, 195, 141, 87, 41, 10, 0, 10, 41, 87, 141, 195}
  };

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sym_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL extra_pulse: sym_valid=1 at cycle %0d, required 0", cyc);
      end else begin
        e = sb.pop_front();
        if (cyc !== e.due) begin
          bad++;
          $display("FAIL pulse_cycle: got %0d required %0d", cyc, e.due);
        end
        total++;
        if (sym_out !== e.sym) begin
          bad++;
          $display("FAIL sym_out: got %b required %b", sym_out, e.sym);
        end
`ifdef QPSK_DEMOD_SYM_ERR_EN
        total++;
        if (sym_err !== e.err) begin
          bad++;
          $display("FAIL sym_err: got %b required %b", sym_err, e.err);
        end
`endif
      end
    end
  end

  task automatic drive(input int s, input logic v, input logic sy);
    @(posedge clk);
    #1;
    sample_in    = s[8:0];
    sample_valid = v;
    sym_sync     = sy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [1:0] s, input logic er, input int due);
    exp_t t;
    t.sym = s;
    t.err = er;
    t.due = due;
    sb.push_back(t);
  endtask

  task automatic send_symbol(input int s, input logic sy, input int gap_after,
                             input int gap_len, input logic er);
    int start;
    start = 0;
    for (int n = 0; n < 16; n++) begin
      drive(wave[s][n], 1'b1, sy && (n == 0));
      if (n == 0) start = cyc;
      if (n == gap_after) begin
        for (int g = 0; g < gap_len; g++) drive(0, 1'b0, 1'b0);
      end
    end
    push(s[1:0], er, start + 17 + gap_len);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL missing_pulse: pending=%0d required 0", sb.size());
      sb.delete();
    end
    idle(4);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total += 3;
    if (sym_out !== 2'b00) begin
      bad++;
      $display("FAIL reset_sym_out: got %b required 00", sym_out);
    end
    if (sym_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_sym_valid: got %b required 0", sym_valid);
    end
    if (locked !== 1'b0) begin
      bad++;
      $display("FAIL reset_locked: got %b required 0", locked);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
  endtask

  task automatic test_single();
    send_symbol(1, 1'b1, 99, 0, 1'b0);
    idle(1);
    drain();
    @(negedge clk);
    total += 3;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL single_locked: got %b required 1", locked);
    end
    if (sym_out !== 2'b01) begin
      bad++;
      $display("FAIL hold_sym_out: got %b required 01", sym_out);
    end
    if (sym_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_sym_valid: got %b required 0", sym_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 4; s++) send_symbol(s, s == 0, 99, 0, 1'b0);
    idle(1);
    drain();
  endtask

  task automatic test_gap();
    send_symbol(1, 1'b1, 7, 3, 1'b0);
    idle(1);
    drain();
  endtask

  task automatic test_resync();
    for (int n = 0; n < 9; n++) drive(wave[0][n], 1'b1, n == 0);
    send_symbol(3, 1'b1, 99, 0, 1'b0);
    idle(1);
    drain();
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 6; n++) drive(wave[1][n], 1'b1, n == 0);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    sample_in    = wave[1][6][8:0];
    sample_valid = 1'b1;
    @(negedge clk);
    total += 3;
    if (locked !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_locked: got %b required 0", locked);
    end
    if (sym_out !== 2'b00) begin
      bad++;
      $display("FAIL rst_mid_sym_out: got %b required 00", sym_out);
    end
    if (sym_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_sym_valid: got %b required 0", sym_valid);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 20; n++) drive(wave[1][n % 16], 1'b1, 1'b0);
    idle(3);
    @(negedge clk);
    total += 2;
    if (locked !== 1'b0) begin
      bad++;
      $display("FAIL hunt_locked: got %b required 0", locked);
    end
    if (sym_out !== 2'b00) begin
      bad++;
      $display("FAIL hunt_sym_out: got %b required 00", sym_out);
    end
    send_symbol(2, 1'b1, 99, 0, 1'b0);
    idle(1);
    drain();
  endtask

  task automatic test_dc_and_confidence();
    int start;
    start = 0;
    for (int n = 0; n < 16; n++) begin
      drive(141, 1'b1, n == 0);
      if (n == 0) start = cyc;
    end
    push(2'b00, 1'b1, start + 17);
    send_symbol(1, 1'b0, 99, 0, 1'b0);
    idle(1);
    drain();
  endtask

  initial begin
    rst          = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    sym_sync     = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_resync();
    test_reset_mid();
    test_dc_and_confidence();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qpsk_symbol_demod.md
Name: qpsk_symbol_demod

Overview:
Receive-side counterpart of the Symbol00..Symbol11 waveform generators. Consumes the 9-bit unsigned 16-samples-per-symbol QPSK waveform (midpoint 141, amplitude 100). Correlates each symbol period against signed cos/sin reference tables and slices the signs of the two correlations into a 2-bit symbol. Sits after the sample mux or channel model, before bit unpacking.

Parameters:
DATA_W, 9, sample width (unsigned)
MID, 141, DC midpoint subtracted from every sample
ERR_THRESH, 20000, minimum |I| and |Q| for a confident decision (SYM_ERR_EN only)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
sample_in  input  DATA_W  waveform sample
sample_valid  input  1  sample_in valid this cycle; gaps allowed
sym_sync  input  1  marks sample_in as sample 0 of a symbol; qualified by sample_valid
sym_out  output  2  decided symbol {cos_bit, sin_bit}
sym_valid  output  1  one-cycle pulse when sym_out updates
locked  output  1  high while in TRACK
sym_err  output  1  low-confidence flag; present only with SYM_ERR_EN

Behaviour:
- Symbol map: bit1=1 means +cos, 0 means -cos; bit0=1 means +sin, 0 means -sin. Symbol01 (-cos+sin) decodes to 2'b01.
- Reset (async): state=HUNT, sample index k=0, accumulators=0, sym_out=0, sym_valid=0, locked=0, sym_err=0. Takes effect mid-symbol; any partial symbol is discarded.
- FSM HUNT: ignores samples until sample_valid && sym_sync. That sample is taken as k=0 and the FSM moves to TRACK.
- FSM TRACK: each valid sample advances k (4-bit, wraps 15 to 0). Invalid cycles hold all state.
- Resync in TRACK: sym_sync with sample_valid at k!=0 forces k=0 and discards the partial symbol, with no sym_valid for it. sym_sync at k==0 is a no-op.
- Stage 1 (registered): xc = signed(sample_in) - MID, 10-bit signed. Also registers k, valid and last=(k==15).
- Stage 2 (registered): acc_i = (k==0 ? 0 : acc_i) + xc*COS[k]; acc_q likewise with SIN[k].
  - Products are 18-bit signed; accumulators are 22-bit signed; there is no saturation.
- Tables: round(127*cos(2πn/16)) and round(127*sin(2πn/16)), 8-bit signed. COS = 127,117,90,49,0,-49,-90,-117,-127,... and SIN is COS shifted by 4 entries.
- Decision: on the stage-2 edge for the last sample, using the final sums (acc + product):
  - sym_out <= {I>0, Q>0}; a sum of exactly 0 slices to 0.
  - sym_valid <= 1 for exactly one cycle.
- Latency: sym_valid rises 2 clock edges after the edge that captures sample 15, provided both cycles are stall-free. The pipeline only advances on valid data, so a gap delays sym_valid by the gap length.
- sym_out holds its value between pulses.
- Back-to-back symbols: sample 0 of the next symbol may arrive the cycle after sample 15. Accumulators reload with no bubble, giving a throughput of 1 symbol per 16 valid samples.

Optional Feature:
QPSK_DEMOD_SYM_ERR_EN
- Defined: adds the sym_err port. sym_err is registered with sym_valid and set to (|I|<ERR_THRESH) || (|Q|<ERR_THRESH).
- Not defined: no sym_err port and no compare logic; the decision path is identical.

Decomposition:
- Shared package qpsk_pkg holds:
  - SPS=16 and MID=141.
  - COS_LUT and SIN_LUT constant arrays.
  - Typedefs sample_t (9-bit unsigned), centered_t (10-bit signed), acc_t (22-bit signed).
  - The symbol encoding constants, shared with the generators.
- One natural sub-module: qpsk_correlator. It holds one MAC lane (table lookup, multiply, accumulate) and is instantiated twice, for the I lane and the Q lane.
- The FSM, index counter and slicer live in the top module.

Test Plan:
- sym_sync + 16 samples of 41,87,141,195,241,272,282,272,241,195,141,87,41,10,0,10 -> sym_valid pulse 2 cycles after the last sample, sym_out=2'b01, locked=1.
- Four symbols back-to-back (the 00, 01, 10, 11 waveforms = 141+100·(±cos±sin)), no gaps -> four sym_valid pulses exactly 16 cycles apart, sym_out 00,01,10,11.
- Same 01 symbol with sample_valid deasserted 3 cycles after sample 7 -> sym_out=01, sym_valid delayed by exactly 3 cycles, no extra pulse.
- sym_sync asserted again at k=9 in TRACK, then a full 11 symbol -> no pulse for the partial symbol; one pulse with sym_out=11.
- rst pulsed at k=6, then samples without sym_sync -> locked=0, no sym_valid, outputs 0; the first sym_sync restarts decoding.
- All samples =141 -> sym_out=00; with QPSK_DEMOD_SYM_ERR_EN, sym_err=1. The 01 waveform gives sym_err=0 (|I|,|Q| ≈ 101600).
